// File: rtl/button_pkg.sv
// button_pkg: state encodings and default 27 MHz timing constants for the button debouncer.
package button_pkg;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PRESS_WAIT = 3'd1;
    localparam logic [2:0] HELD       = 3'd2;
    localparam logic [2:0] LONG_HELD  = 3'd3;
    localparam logic [2:0] REL_WAIT_S = 3'd4;
    localparam logic [2:0] REL_WAIT_L = 3'd5;

    // 10 ms debounce and 1 s long-press at 27 MHz
    localparam int DEBOUNCE_CYCLES_27M = 270000;
    localparam int LONG_CYCLES_27M     = 27000000;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset; both flops load RESET_VAL
//   d     in  asynchronous input
//   q     out synchronized output, 2 cycles latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces a push-button pin into level and event pulses.
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   btn_raw     in  asynchronous button pin
//   btn_level   out debounced state, 1 = pressed
//   btn_press   out one-cycle pulse on accepted press
//   btn_release out one-cycle pulse on accepted release
//   btn_long    out one-cycle pulse when a press has been held LONG_CYCLES
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_27M,
    parameter int LONG_CYCLES     = LONG_CYCLES_27M,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic          pin_s, p;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d, press_q, press_d, release_q, release_d, long_q, long_d;

    sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (pin_s)
    );

    assign p = pin_s ^ ACTIVE_LOW;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = p ? PRESS_WAIT : IDLE;
            PRESS_WAIT: state_d = !p ? IDLE : (cnt_q == DB_LAST) ? HELD : PRESS_WAIT;
            // a release seen on the long-press cycle wins: no long pulse
            HELD:       state_d = !p ? REL_WAIT_S : (cnt_q == LONG_LAST) ? LONG_HELD : HELD;
            LONG_HELD:  state_d = p ? LONG_HELD : REL_WAIT_L;
            REL_WAIT_S: state_d = p ? HELD : (cnt_q == DB_LAST) ? IDLE : REL_WAIT_S;
            REL_WAIT_L: state_d = p ? LONG_HELD : (cnt_q == DB_LAST) ? IDLE : REL_WAIT_L;
            default:    state_d = IDLE;
        endcase
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        // every state entry restarts the counter, so HELD re-entered after a
        // bounce measures long-press time from the last stable press
        cnt_d     = (state_d != state_q) ? '0 : cnt_inc;
        press_d   = (state_q == PRESS_WAIT) && (state_d == HELD);
        long_d    = (state_q == HELD) && (state_d == LONG_HELD);
        release_d = (state_d == IDLE) && ((state_q == REL_WAIT_S) || (state_q == REL_WAIT_L));
        level_d   = (state_d == HELD) || (state_d == LONG_HELD) ||
                    (state_d == REL_WAIT_S) || (state_d == REL_WAIT_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed stimulus with a behavioural debounce model and literal timing checks.
module tb_button_debounce;
    import button_pkg::*;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0, rst_n = 1'b0, btn_raw = 1'b1;
    logic btn_level, btn_press, btn_release, btn_long;
    int   vectors = 0, miscompares = 0, cyc = 0;
    int   n_press = 0, n_rel = 0, n_long = 0, t_press = 0, t_rel = 0, t_long = 0;
    int   c0, b_press, b_rel, b_long, pe;

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    // Model: p at edge n is the pin sampled at edge n-2. A change is accepted after
    // D+1 consecutive samples of the new value; long fires L edges after the hold
    // (re)started: the press edge, or the edge the pressed value returned after a bounce.
    logic mp, h1 = 1'b1, h2 = 1'b1, pp = 1'b0;
    logic lvl = 1'b0, ep = 1'b0, er = 1'b0, el = 1'b0, ldone = 1'b0;
    int   run1 = 0, run0 = 0, t = 0, start = 0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            h1 = 1'b1; h2 = 1'b1; pp = 1'b0; run1 = 0; run0 = 0;
            lvl = 1'b0; ep = 1'b0; er = 1'b0; el = 1'b0; ldone = 1'b0;
        end else begin
            t++;
            mp = ~h2;
            h2 = h1;
            h1 = btn_raw;
            run1 = mp ? run1 + 1 : 0;
            run0 = mp ? 0 : run0 + 1;
            ep = 1'b0; er = 1'b0; el = 1'b0;
            if (!lvl && run1 == D + 1) begin
                lvl = 1'b1; ep = 1'b1; start = t; ldone = 1'b0;
            end else if (lvl && run0 == D + 1) begin
                lvl = 1'b0; er = 1'b1;
            end else if (lvl && mp && !pp) begin
                start = t;
            end else if (lvl && mp && !ldone && t - start == L) begin
                el = 1'b1; ldone = 1'b1;
            end
            pp = mp;
        end
    end

    initial forever begin
        @(negedge clk);
        vectors++;
        if ({btn_level, btn_press, btn_release, btn_long} !== {lvl, ep, er, el}) begin
            miscompares++;
            $display("FAIL cycle %0d: level/press/release/long = %b%b%b%b, model wants %b%b%b%b",
                     cyc, btn_level, btn_press, btn_release, btn_long, lvl, ep, er, el);
        end
        if (btn_press)   begin n_press++; t_press = cyc; end
        if (btn_release) begin n_rel++;   t_rel   = cyc; end
        if (btn_long)    begin n_long++;  t_long  = cyc; end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: run did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        step(3);
        rst_n = 1'b1;

        // 1: idle with pin released
        step(50);
        chk("t1_events", n_press + n_rel + n_long, 0);
        chk("t1_level", int'(btn_level), 0);
        chk("t1_state", int'(dut.state_q), int'(IDLE));

        // 2: clean press then clean release
        btn_raw = 1'b0; c0 = cyc + 1;
        step(12);
        chk("t2_press_cnt", n_press, 1);
        chk("t2_press_lat", t_press - c0, 6);
        chk("t2_level", int'(btn_level), 1);
        btn_raw = 1'b1; c0 = cyc + 1;
        step(10);
        chk("t2_rel_cnt", n_rel, 1);
        chk("t2_rel_lat", t_rel - c0, 6);
        chk("t2_no_long", n_long, 0);

        // 3: short low glitches, then a real press
        b_press = n_press;
        for (int i = 0; i < 5; i++) begin
            btn_raw = 1'b0; step(3);
            btn_raw = 1'b1; step(2);
        end
        step(6);
        chk("t3_glitch_press", n_press, b_press);
        chk("t3_glitch_level", int'(btn_level), 0);
        btn_raw = 1'b0; c0 = cyc + 1;
        step(10);
        chk("t3_press_cnt", n_press, b_press + 1);
        chk("t3_press_lat", t_press - c0, 6);

        // 4: long press, release, no second long
        step(26);
        chk("t4_long_cnt", n_long, 1);
        chk("t4_long_lat", t_long - t_press, 20);
        btn_raw = 1'b1; c0 = cyc + 1;
        step(10);
        chk("t4_rel_lat", t_rel - c0, 6);
        chk("t4_level", int'(btn_level), 0);
        chk("t4_long_once", n_long, 1);

        // 5: release glitch reaching the FSM on the would-be long cycle
        b_press = n_press; b_rel = n_rel; b_long = n_long;
        btn_raw = 1'b0;
        for (int i = 0; i < 20 && n_press == b_press; i++) step(1);
        chk("t5_press_cnt", n_press, b_press + 1);
        pe = t_press;
        step(17);
        btn_raw = 1'b1;
        step(2);
        btn_raw = 1'b0;
        step(30);
        chk("t5_no_rel", n_rel, b_rel);
        chk("t5_long_cnt", n_long, b_long + 1);
        chk("t5_long_at", t_long - pe, 42);
        chk("t5_level", int'(btn_level), 1);

        // 6: reset while pressed, button still held
        b_rel = n_rel; b_press = n_press;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", int'({btn_level, btn_press, btn_release, btn_long}), 0);
        step(2);
        rst_n = 1'b1; c0 = cyc + 1;
        step(10);
        chk("t6_press_cnt", n_press, b_press + 1);
        chk("t6_press_lat", t_press - c0, 6);
        chk("t6_no_rel", n_rel, b_rel);
        chk("t6_level", int'(btn_level), 1);

        btn_raw = 1'b1;
        step(10);
        chk("t6_final_rel", n_rel, b_rel + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
